// File: rtl/hit_pattern_injector.sv
// Purpose: self-test source that drives six layer buses with programmed hit patterns in timed bursts.
// Latency: with start sampled at edge N, the first pulse appears after edge N+1+delay; all outputs are registered.
// Backpressure: none; start while busy is ignored, trig_stop aborts the burst at the next edge.
module hit_pattern_injector #(
  parameter int WIDTH    = 48,
  parameter int DLY_BITS = 8,
  parameter int PW_BITS  = 4,
  parameter int REP_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [2:0]          wr_layer,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                start,
  input  logic [DLY_BITS-1:0] delay,
  input  logic [PW_BITS-1:0]  pwidth,
  input  logic [DLY_BITS-1:0] gap,
  input  logic [REP_BITS-1:0] reps,
  input  logic                trig_stop,
  output logic [WIDTH-1:0]    ly0,
  output logic [WIDTH-1:0]    ly1,
  output logic [WIDTH-1:0]    ly2,
  output logic [WIDTH-1:0]    ly3,
  output logic [WIDTH-1:0]    ly4,
  output logic [WIDTH-1:0]    ly5,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [REP_BITS-1:0] inj_count
);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_FIRE, S_GAP, S_FIN} state_t;

  localparam logic [DLY_BITS-1:0] ONE_D = DLY_BITS'(1);
  localparam logic [REP_BITS-1:0] ONE_R = REP_BITS'(1);

  state_t              state_q, state_d;
  logic [DLY_BITS-1:0] cnt_q, cnt_d;
  logic [PW_BITS-1:0]  pw_q, pw_d;
  logic [DLY_BITS-1:0] gap_q, gap_d;
  logic [REP_BITS-1:0] reps_q, reps_d;
  logic [REP_BITS-1:0] inj_q, inj_d;
  logic [WIDTH-1:0]    pattern_q [6];
  logic [WIDTH-1:0]    pattern_d [6];
  logic [WIDTH-1:0]    ly_q [6];
  logic [WIDTH-1:0]    ly_d [6];
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                abort_now;

  // Zero pulse width or gap still yields one cycle, so the one-shots always see an edge and a re-arm gap.
  function automatic logic [DLY_BITS-1:0] pw_len(input logic [PW_BITS-1:0] p);
    return (p == '0) ? ONE_D : DLY_BITS'(p);
  endfunction

  function automatic logic [DLY_BITS-1:0] gap_len(input logic [DLY_BITS-1:0] g);
    return (g == '0) ? ONE_D : g;
  endfunction

  // State register plus all datapath and output flops; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pw_q      <= '0;
      gap_q     <= '0;
      reps_q    <= '0;
      inj_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        pattern_q[k] <= '0;
        ly_q[k]      <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pw_q      <= pw_d;
      gap_q     <= gap_d;
      reps_q    <= reps_d;
      inj_q     <= inj_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      for (int k = 0; k < 6; k++) begin
        pattern_q[k] <= pattern_d[k];
        ly_q[k]      <= ly_d[k];
      end
    end
  end

  // Next state, burst counters and pattern writes (writes only land while the FSM is idle).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pw_d      = pw_q;
    gap_d     = gap_q;
    reps_d    = reps_q;
    inj_d     = inj_q;
    abort_now = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pattern_d[k] = pattern_q[k];
      if (wr_en && (wr_layer <= 3'd5) && (state_q == S_IDLE) && (wr_layer == 3'(k))) begin
        pattern_d[k] = wr_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !trig_stop) begin
          pw_d   = pwidth;
          gap_d  = gap;
          reps_d = reps;
          inj_d  = '0;
          if (reps == '0) begin
            state_d = S_FIN;
          end else if (delay != '0) begin
            state_d = S_DELAY;
            cnt_d   = delay - ONE_D;
          end else begin
            state_d = S_FIRE;
            cnt_d   = pw_len(pwidth) - ONE_D;
          end
        end
      end
      S_DELAY: begin
        if (trig_stop) begin
          state_d   = S_IDLE;
          abort_now = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_FIRE;
          cnt_d   = pw_len(pw_q) - ONE_D;
        end else begin
          cnt_d = cnt_q - ONE_D;
        end
      end
      S_FIRE: begin
        if (trig_stop) begin
          state_d   = S_IDLE;
          abort_now = 1'b1;
        end else if (cnt_q == '0) begin
          inj_d = (inj_q == '1) ? inj_q : inj_q + ONE_R;
          if (reps_q == ONE_R) begin
            state_d = S_FIN;
          end else begin
            reps_d  = reps_q - ONE_R;
            state_d = S_GAP;
            cnt_d   = gap_len(gap_q) - ONE_D;
          end
        end else begin
          cnt_d = cnt_q - ONE_D;
        end
      end
      S_GAP: begin
        if (trig_stop) begin
          state_d   = S_IDLE;
          abort_now = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_FIRE;
          cnt_d   = pw_len(pw_q) - ONE_D;
        end else begin
          cnt_d = cnt_q - ONE_D;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the current state; a stop in FIRE blanks the layers at the same edge.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      ly_d[k] = ((state_q == S_FIRE) && !trig_stop) ? pattern_q[k] : '0;
    end
    busy_d    = (state_q != S_IDLE) && !abort_now;
    done_d    = (state_q == S_FIN);
    aborted_d = abort_now;
  end

  assign ly0       = ly_q[0];
  assign ly1       = ly_q[1];
  assign ly2       = ly_q[2];
  assign ly3       = ly_q[3];
  assign ly4       = ly_q[4];
  assign ly5       = ly_q[5];
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign inj_count = inj_q;

endmodule
